// File: rtl/addr_calc_pkg.sv
// Shared types and screen defaults for the frame-buffer address pipeline.
package addr_calc_pkg;

  localparam int unsigned SCREEN_WIDTH_DEF  = 640;
  localparam int unsigned SCREEN_HEIGHT_DEF = 480;

  typedef logic [31:0] addr_t;
  typedef logic [9:0]  coord_t;

endpackage

// File: rtl/addr_calculator.sv
// Two-stage pixel address pipeline: offset + (y*W + x) * size.
// Bounds flag enabled by ADDR_CALC_BOUNDS_CHECK_EN.
module addr_calculator
  import addr_calc_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
  parameter int unsigned SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
  parameter int unsigned PIXELBITS     = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  input  logic [PIXELBITS-1:0] pixel_size,
  input  logic [31:0]          offset,
`ifdef ADDR_CALC_BOUNDS_CHECK_EN
  output logic                 out_of_range,
`endif
  output logic [31:0]          address
);

  // Index width covers y up to 1023 rows plus a full row of x.
  localparam int unsigned IDX_W  =
    10 + $clog2(SCREEN_WIDTH + 1) + 1;
  localparam int unsigned PROD_W = IDX_W + PIXELBITS;

  logic [IDX_W-1:0]     idx_d, idx_q;
  logic [PIXELBITS-1:0] size_d, size_q;
  addr_t                offs_d, offs_q;
  addr_t                address_d, address_q;
  logic [PROD_W-1:0]    prod;
  coord_t               x_c, y_c;

  assign x_c = x;
  assign y_c = y;

`ifdef ADDR_CALC_BOUNDS_CHECK_EN
  logic oor_d, oor_q;
  logic out_of_range_d, out_of_range_q;
`endif

  always_comb begin
    idx_d  = IDX_W'(y_c) * IDX_W'(SCREEN_WIDTH)
           + IDX_W'(x_c);
    size_d = (pixel_size == '0)
           ? PIXELBITS'(1) : pixel_size;
    offs_d = offset;
`ifdef ADDR_CALC_BOUNDS_CHECK_EN
    oor_d = (32'(x_c) >= SCREEN_WIDTH)
         || (32'(y_c) >= SCREEN_HEIGHT);
    // Zeroing the index makes the result collapse to offset.
    if (oor_d) idx_d = '0;
`endif
  end

  always_comb begin
    prod      = PROD_W'(idx_q) * PROD_W'(size_q);
    address_d = offs_q + 32'(prod);
`ifdef ADDR_CALC_BOUNDS_CHECK_EN
    out_of_range_d = oor_q;
`endif
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idx_q     <= '0;
      size_q    <= '0;
      offs_q    <= '0;
      address_q <= '0;
    end else begin
      idx_q     <= idx_d;
      size_q    <= size_d;
      offs_q    <= offs_d;
      address_q <= address_d;
    end
  end

`ifdef ADDR_CALC_BOUNDS_CHECK_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      oor_q          <= 1'b0;
      out_of_range_q <= 1'b0;
    end else begin
      oor_q          <= oor_d;
      out_of_range_q <= out_of_range_d;
    end
  end

  assign out_of_range = out_of_range_q;
`endif

  assign address = address_q;

endmodule

// File: tb/tb_addr_calculator.sv
// Directed-vector bench for addr_calculator.
// Covers reset, latency, streaming, wrap and bounds behaviour.
module tb_addr_calculator;

  logic        clk;
  logic        n_rst;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [3:0]  pixel_size;
  logic [31:0] offset;
  logic [31:0] address;
`ifdef ADDR_CALC_BOUNDS_CHECK_EN
  logic        out_of_range;
`endif

  int checks;
  int errors;

  addr_calculator dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .x            (x),
    .y            (y),
    .pixel_size   (pixel_size),
    .offset       (offset),
`ifdef ADDR_CALC_BOUNDS_CHECK_EN
    .out_of_range (out_of_range),
`endif
    .address      (address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [9:0] xi,
                       input logic [9:0] yi,
                       input logic [3:0] si,
                       input logic [31:0] oi);
    x          = xi;
    y          = yi;
    pixel_size = si;
    offset     = oi;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n_rst  = 1'b0;
    drive(10'd7, 10'd3, 4'd8, 32'h1234_5678);
    #2;
    check("reset_addr", address, 32'h0);
`ifdef ADDR_CALC_BOUNDS_CHECK_EN
    check("reset_oor", {31'd0, out_of_range}, 32'h0);
`endif
    tick();
    check("reset_held", address, 32'h0);
    n_rst = 1'b1;

    // first valid result on second edge after release
    drive(10'd0, 10'd0, 4'd8, 32'h0800_0000);
    tick();
    check("post_rst_e1", address, 32'h0);
    tick();
    check("base", address, 32'h0800_0000);

    drive(10'd2, 10'd1, 4'd8, 32'h0800_0000);
    tick();
    tick();
    check("linear", address, 32'h0800_1410);
    tick();
    check("hold", address, 32'h0800_1410);

    // back-to-back streaming
    drive(10'd0, 10'd0, 4'd8, 32'h0800_0000);
    tick();
    drive(10'd2, 10'd1, 4'd8, 32'h0800_0000);
    tick();
    check("b2b_first", address, 32'h0800_0000);
    tick();
    check("b2b_second", address, 32'h0800_1410);

    drive(10'd5, 10'd0, 4'd0, 32'hFFFF_FFFE);
    tick();
    tick();
    check("zero_size_wrap", address, 32'h0000_0003);

    drive(10'd2, 10'd1, 4'd8, 32'hFFFF_F000);
    tick();
    tick();
    check("sum_wrap", address, 32'h0000_0410);

    drive(10'd639, 10'd479, 4'd15, 32'h0);
    tick();
    tick();
    check("corner_max", address, 32'h0046_4FF1);
`ifdef ADDR_CALC_BOUNDS_CHECK_EN
    check("corner_oor", {31'd0, out_of_range}, 32'h0);
`endif

    drive(10'd640, 10'd0, 4'd8, 32'h0000_1000);
    tick();
    tick();
`ifdef ADDR_CALC_BOUNDS_CHECK_EN
    check("x_oob_addr", address, 32'h0000_1000);
    check("x_oob_flag", {31'd0, out_of_range}, 32'h1);
`else
    check("x_oob_addr", address, 32'h0000_2400);
`endif

    drive(10'd0, 10'd480, 4'd1, 32'h0);
    tick();
    tick();
`ifdef ADDR_CALC_BOUNDS_CHECK_EN
    check("y_oob_addr", address, 32'h0);
    check("y_oob_flag", {31'd0, out_of_range}, 32'h1);
`else
    check("y_oob_addr", address, 32'h0004_B000);
`endif

    drive(10'd1023, 10'd1023, 4'd15, 32'h0);
    tick();
    tick();
`ifdef ADDR_CALC_BOUNDS_CHECK_EN
    check("max_oob_addr", address, 32'h0);
    check("max_oob_flag", {31'd0, out_of_range}, 32'h1);
`else
    check("max_oob_addr", address, 32'h0096_1671);
`endif

    // mid-operation reset discards in-flight data
    drive(10'd2, 10'd1, 4'd8, 32'h0800_0000);
    tick();
    tick();
    check("pre_midrst", address, 32'h0800_1410);
    #2;
    n_rst = 1'b0;
    #1;
    check("midrst_addr", address, 32'h0);
`ifdef ADDR_CALC_BOUNDS_CHECK_EN
    check("midrst_oor", {31'd0, out_of_range}, 32'h0);
`endif
    tick();
    n_rst = 1'b1;
    drive(10'd0, 10'd0, 4'd8, 32'h0800_0000);
    tick();
    check("rerst_e1", address, 32'h0);
    tick();
    check("rerst_e2", address, 32'h0800_0000);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/addr_calculator.md
ADDR_CALCULATOR -- requirements
Module: addr_calculator

Interface
REQ-001 Parameter SCREEN_WIDTH, default 640, pixels per row.
REQ-002 Parameter SCREEN_HEIGHT, default 480, rows per frame.
REQ-003 Parameter PIXELBITS, default 4, width of pixel_size.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 n_rst  input  1  reset, asynchronous, active-low.
REQ-006 x  input  10  unsigned pixel column.
REQ-007 y  input  10  unsigned pixel row.
REQ-008 pixel_size  input  PIXELBITS  bytes per pixel, unsigned.
REQ-009 offset  input  32  frame-buffer base byte address.
REQ-010 address  output  32  computed byte address, registered.
REQ-011 out_of_range  output  1  registered; present only when ADDR_CALC_BOUNDS_CHECK_EN is defined.

Function
REQ-012 The block SHALL compute address = offset + (y*SCREEN_WIDTH + x) * eff_size, modulo 2^32.
REQ-013 eff_size SHALL equal pixel_size, except pixel_size = 0 SHALL be treated as 1.
REQ-014 Stage 1 SHALL register the linear index y*SCREEN_WIDTH + x (at least 20 bits), plus eff_size and offset.
REQ-015 Stage 2 SHALL register index*eff_size + offset into address.
REQ-016 Latency SHALL be exactly 2 rising edges from stable inputs to address.
REQ-017 The pipeline SHALL accept new inputs every cycle with no stalls, handshake or back-pressure.
REQ-018 Intermediate products SHALL be computed at full width; only the final sum truncates to 32 bits, wrapping silently.
REQ-019 Inputs held constant SHALL yield a constant address from the second edge onward.

Reset
REQ-020 While n_rst = 0, all pipeline registers, address and out_of_range SHALL be 0, independent of clk.
REQ-021 After n_rst deasserts, the first valid address SHALL appear on the second rising edge.
REQ-022 Reset asserted mid-operation SHALL discard all in-flight values immediately.

Configuration
REQ-023 Macro ADDR_CALC_BOUNDS_CHECK_EN SHALL control bounds checking.
REQ-024 With the macro defined:
- out_of_range SHALL be 1 with the same latency as address when x >= SCREEN_WIDTH or y >= SCREEN_HEIGHT.
- In that case address SHALL equal offset.
REQ-025 Without the macro:
- out_of_range SHALL not exist.
- Out-of-range coordinates SHALL be computed by the REQ-012 formula unchanged.

Structure
REQ-026 Package addr_calc_pkg SHALL hold:
- the SCREEN_WIDTH and SCREEN_HEIGHT defaults;
- the 32-bit address typedef;
- the 10-bit coordinate typedef.
REQ-027 The block SHALL be a single module with no sub-modules; the multiply-add lives inline in the two pipeline stages.

Verification
REQ-028 Reset: drive n_rst = 0 with nonzero inputs -> address = 0 (and out_of_range = 0) immediately, without a clock edge.
REQ-029 Base case: x=0, y=0, pixel_size=8, offset=0x08000000 -> address = 0x08000000 after 2 edges.
REQ-030 Linear case: x=2, y=1, pixel_size=8, offset=0x08000000 -> address = 0x08001410 (index 642 * 8 = 5136) after 2 edges.
REQ-031 Back-to-back: present REQ-029 then REQ-030 inputs on consecutive cycles -> 0x08000000 then 0x08001410 on consecutive cycles.
REQ-032 Zero size and wrap: pixel_size=0, x=5, y=0, offset=0xFFFFFFFE -> address = 0x00000003.
REQ-033 Bounds, macro defined: x=640, y=0, offset=0x1000 -> out_of_range = 1 and address = 0x1000; without the macro -> address = 0x1000 + 640*eff_size.
